// File: rtl/gray_counter.sv
// gray_counter: up/down/load binary+Gray counter with wrap pulse and a two-stage
// pipelined binary<->Gray converter sharing the same conversion functions.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  input  logic             conv_valid_i,
  input  logic             conv_mode_i,
  input  logic [WIDTH-1:0] conv_in_i,
  output logic             conv_valid_o,
  output logic [WIDTH-1:0] conv_out_o
);
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [WIDTH-1:0] bin_q, bin_d, gray_q;
  logic             wrap_q, wrap_d;
  logic             s1_valid_q, s1_mode_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             conv_valid_q;
  logic [WIDTH-1:0] conv_out_q, conv_out_d;
  // load wins over stepping, so a load never raises wrap
  always_comb begin
    bin_d      = load_i ? din_i : enable_i ? (up_i ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1)) : bin_q;
    wrap_d     = !load_i && enable_i && (up_i ? &bin_q : ~|bin_q);
    conv_out_d = s1_valid_q ? (s1_mode_q ? gray2bin(s1_data_q) : bin2gray(s1_data_q)) : conv_out_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q        <= '0;
      gray_q       <= '0;
      wrap_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_data_q    <= '0;
      conv_valid_q <= 1'b0;
      conv_out_q   <= '0;
    end else begin
      bin_q        <= bin_d;
      gray_q       <= bin2gray(bin_d);
      wrap_q       <= wrap_d;
      s1_valid_q   <= conv_valid_i;
      s1_mode_q    <= conv_valid_i ? conv_mode_i : s1_mode_q;
      s1_data_q    <= conv_valid_i ? conv_in_i : s1_data_q;
      conv_valid_q <= s1_valid_q;
      conv_out_q   <= conv_out_d;
    end
  end
  assign bin_o        = bin_q;
  assign gray_o       = gray_q;
  assign wrap_o       = wrap_q;
  assign conv_valid_o = conv_valid_q;
  assign conv_out_o   = conv_out_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of the 4-bit counter/converter, the 2-bit wrap
// corner and a full 8-bit count-up sweep.
module tb_gray_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       en4 = 0, up4 = 0, ld4 = 0, cvi4 = 0, cm4 = 0;
  logic [3:0] din4 = '0, ci4 = '0;
  logic [3:0] bin4, gray4, co4;
  logic       wrap4, cvo4;
  logic       en2 = 0, up2 = 0, ld2 = 0;
  logic [1:0] din2 = '0;
  logic [1:0] bin2, gray2, co2;
  logic       wrap2, cvo2;
  logic       en8 = 0, up8 = 0;
  logic [7:0] bin8, gray8, co8, prev8;
  logic       wrap8, cvo8;
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  gray_counter #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en4), .up_i(up4), .load_i(ld4), .din_i(din4),
    .bin_o(bin4), .gray_o(gray4), .wrap_o(wrap4), .conv_valid_i(cvi4), .conv_mode_i(cm4),
    .conv_in_i(ci4), .conv_valid_o(cvo4), .conv_out_o(co4));
  gray_counter #(.WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en2), .up_i(up2), .load_i(ld2), .din_i(din2),
    .bin_o(bin2), .gray_o(gray2), .wrap_o(wrap2), .conv_valid_i(1'b0), .conv_mode_i(1'b0),
    .conv_in_i(2'b00), .conv_valid_o(cvo2), .conv_out_o(co2));
  gray_counter #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(en8), .up_i(up8), .load_i(1'b0), .din_i(8'h00),
    .bin_o(bin8), .gray_o(gray8), .wrap_o(wrap8), .conv_valid_i(1'b0), .conv_mode_i(1'b0),
    .conv_in_i(8'h00), .conv_valid_o(cvo8), .conv_out_o(co8));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  initial begin
    #2;
    chk("rst_bin", bin4, 0);
    chk("rst_gray", gray4, 0);
    chk("rst_wrap", wrap4, 0);
    chk("rst_cvo", cvo4, 0);
    chk("rst_co", co4, 0);
    #1 rst = 0;
    en4 = 1; up4 = 1;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("up_bin", bin4, i);
      chk("up_gray", gray4, gtab[i]);
      chk("up_wrap", wrap4, 0);
    end
    step();
    chk("upwrap_bin", bin4, 0);
    chk("upwrap_gray", gray4, 0);
    chk("upwrap_wrap", wrap4, 1);
    en4 = 0;
    step();
    chk("hold_bin", bin4, 0);
    chk("wrap_once", wrap4, 0);
    en4 = 1; up4 = 0;
    step();
    chk("dn_bin", bin4, 15);
    chk("dn_gray", gray4, 4'b1000);
    chk("dn_wrap", wrap4, 1);
    step();
    chk("dn2_bin", bin4, 14);
    chk("dn2_gray", gray4, 4'b1001);
    chk("dn2_wrap", wrap4, 0);
    ld4 = 1; din4 = 9;
    step();
    chk("ld_bin", bin4, 9);
    chk("ld_gray", gray4, 4'b1101);
    chk("ld_wrap", wrap4, 0);
    ld4 = 0; up4 = 1;
    repeat (6) step();
    chk("to15_bin", bin4, 15);
    ld4 = 1; din4 = 15;
    step();
    chk("ld15_bin", bin4, 15);
    chk("ld15_wrap", wrap4, 0);
    ld4 = 0;
    step();
    chk("post_ld_bin", bin4, 0);
    chk("post_ld_wrap", wrap4, 1);
    en4 = 0;
    cvi4 = 1; cm4 = 0; ci4 = 4'b1011;
    step();
    chk("cv_lat1", cvo4, 0);
    cm4 = 1; ci4 = 4'b1110;
    step();
    cvi4 = 0;
    chk("cv_a_valid", cvo4, 1);
    chk("cv_a_b2g", co4, 4'b1110);
    step();
    chk("cv_b_valid", cvo4, 1);
    chk("cv_b_g2b", co4, 4'b1011);
    step();
    chk("cv_idle_valid", cvo4, 0);
    chk("cv_idle_hold", co4, 4'b1011);
    ld4 = 1; din4 = 6;
    step();
    ld4 = 0;
    chk("pre_rst_bin", bin4, 6);
    chk("pre_rst_gray", gray4, 4'b0101);
    cvi4 = 1; cm4 = 0; ci4 = 4'b0101;
    step();
    cvi4 = 0;
    #2 rst = 1;
    #1;
    chk("arst_bin", bin4, 0);
    chk("arst_gray", gray4, 0);
    chk("arst_wrap", wrap4, 0);
    chk("arst_cvo", cvo4, 0);
    chk("arst_co", co4, 0);
    #2 rst = 0;
    step();
    chk("post_rst_cvo1", cvo4, 0);
    step();
    chk("post_rst_cvo2", cvo4, 0);
    chk("post_rst_co", co4, 0);
    en4 = 1; up4 = 1;
    step();
    chk("post_rst_step", bin4, 1);
    en4 = 0;
    ld2 = 1; din2 = 3;
    step();
    chk("w2_ld_bin", bin2, 3);
    chk("w2_ld_gray", gray2, 2'b10);
    ld2 = 0; en2 = 1; up2 = 1;
    step();
    chk("w2_wrap_bin", bin2, 0);
    chk("w2_wrap_gray", gray2, 0);
    chk("w2_wrap", wrap2, 1);
    en2 = 0;
    prev8 = gray8;
    en8 = 1; up8 = 1;
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("w8_bin", bin8, i[7:0]);
      chk("w8_onebit", $countones(gray8 ^ prev8), 1);
      chk("w8_g2b", g2b8(gray8), bin8);
      chk("w8_wrap", wrap8, i == 256);
      prev8 = gray8;
    end
    en8 = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
